// File: rtl/seg_display_scan.sv
// seg_display_scan: latches six ASCII digits plus flags, decodes them to 7-segment and scans a 6-digit display.
// Optional macro DISP_PWM_EN adds a brightness[2:0] input that PWM-gates digit_en inside each lit slot.
module seg_display_scan #(
  parameter int SCAN_DIV     = 32,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] lower0001,
  input  logic [7:0] lower0010,
  input  logic [7:0] lower0100,
  input  logic [7:0] lower1000,
  input  logic [7:0] upper01,
  input  logic [7:0] upper10,
  input  logic       point,
  input  logic       col,
  input  logic       AVS,
  input  logic       DAY,
  input  logic       MAX,
  input  logic       TIM,
`ifdef DISP_PWM_EN
  input  logic [2:0] brightness,
`endif
  output logic       load_ack,
  output logic [7:0] seg,
  output logic [5:0] digit_en,
  output logic       colon,
  output logic [3:0] ann,
  output logic       frame_start
);

  localparam int PC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef struct packed {
    logic [5:0][7:0] chr;
    logic            pt;
    logic            col;
    logic [3:0]      ann;
  } frame_t;

  localparam frame_t BLANK_FRAME = frame_t'({{6{8'h20}}, 6'b0});

  function automatic logic [6:0] decode7(input logic [7:0] c);
    case (c)
      8'h30:   decode7 = 7'h3F;
      8'h31:   decode7 = 7'h06;
      8'h32:   decode7 = 7'h5B;
      8'h33:   decode7 = 7'h4F;
      8'h34:   decode7 = 7'h66;
      8'h35:   decode7 = 7'h6D;
      8'h36:   decode7 = 7'h7D;
      8'h37:   decode7 = 7'h07;
      8'h38:   decode7 = 7'h7F;
      8'h39:   decode7 = 7'h6F;
      8'h2D:   decode7 = 7'h40;
      default: decode7 = 7'h00;
    endcase
  endfunction

  frame_t          shadow_q, shadow_d;
  frame_t          active_q, active_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      seg_q, seg_d;
  logic [5:0]      digit_en_q, digit_en_d;
  logic            load_ack_q, load_ack_d;
  logic            frame_start_q, frame_start_d;
  logic            pc_last;
  logic            wrap;
`ifdef DISP_PWM_EN
  logic [2:0]      bright_q, bright_d;
  logic [2:0]      pwm_phase;
`endif

  always_comb begin
    pc_last       = (pc_q == PC_W'(SCAN_DIV - 1));
    wrap          = pc_last && (idx_q == 3'd5);
    pc_d          = pc_last ? '0 : pc_q + PC_W'(1);
    idx_d         = idx_q;
    if (pc_last) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

    // Refresh copies the pre-load shadow; a coincident load lands in the next frame.
    shadow_d = shadow_q;
    if (load) begin
      shadow_d.chr = {upper10, upper01, lower1000, lower0100, lower0010, lower0001};
      shadow_d.pt  = point;
      shadow_d.col = col;
      shadow_d.ann = {TIM, MAX, DAY, AVS};
    end
    active_d = wrap ? shadow_q : active_q;

    load_ack_d    = load;
    frame_start_d = wrap;
    seg_d         = 8'h00;
    digit_en_d    = 6'b0;
`ifdef DISP_PWM_EN
    bright_d  = wrap ? brightness : bright_q;
    pwm_phase = 3'(pc_q - PC_W'(BLANK_CYCLES));
`endif
    if (pc_q >= PC_W'(BLANK_CYCLES)) begin
      seg_d      = {(idx_q == 3'd1) && active_q.pt, decode7(active_q.chr[idx_q])};
      digit_en_d = 6'b1 << idx_q;
`ifdef DISP_PWM_EN
      if (pwm_phase > bright_q) digit_en_d = 6'b0;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q      <= BLANK_FRAME;
      active_q      <= BLANK_FRAME;
      pc_q          <= '0;
      idx_q         <= 3'd0;
      seg_q         <= 8'h00;
      digit_en_q    <= 6'b0;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef DISP_PWM_EN
      bright_q      <= 3'd7;
`endif
    end else begin
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pc_q          <= pc_d;
      idx_q         <= idx_d;
      seg_q         <= seg_d;
      digit_en_q    <= digit_en_d;
      load_ack_q    <= load_ack_d;
      frame_start_q <= frame_start_d;
`ifdef DISP_PWM_EN
      bright_q      <= bright_d;
`endif
    end
  end

  assign seg         = seg_q;
  assign digit_en    = digit_en_q;
  assign load_ack    = load_ack_q;
  assign frame_start = frame_start_q;
  assign colon       = active_q.col;
  assign ann         = active_q.ann;

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: directed and random loads checked every cycle against a frame-level model.
module tb_seg_display_scan;
  localparam int SD = 32;
  localparam int BC = 2;
  localparam int FR = 6 * SD;

  typedef struct packed {
    logic [5:0][7:0] chr;
    logic            pt;
    logic            col;
    logic [3:0]      ann;
  } buf_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load  = 1'b0;
  logic [7:0] lower0001, lower0010, lower0100, lower1000, upper01, upper10;
  logic       point, col, AVS, DAY, MAX, TIM;
  logic       load_ack, colon, frame_start;
  logic [7:0] seg;
  logic [5:0] digit_en;
  logic [3:0] ann;
`ifdef DISP_PWM_EN
  logic [2:0] brightness = 3'd7;
`endif

  seg_display_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clock(clock), .reset(reset), .load(load),
    .lower0001(lower0001), .lower0010(lower0010), .lower0100(lower0100),
    .lower1000(lower1000), .upper01(upper01), .upper10(upper10),
    .point(point), .col(col), .AVS(AVS), .DAY(DAY), .MAX(MAX), .TIM(TIM),
`ifdef DISP_PWM_EN
    .brightness(brightness),
`endif
    .load_ack(load_ack), .seg(seg), .digit_en(digit_en), .colon(colon),
    .ann(ann), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  int   ncmp = 0;
  int   nfail = 0;
  int   e = 0;
  buf_t nxt, m_sh, m_act, blank_buf;
  int   m_br = 7;

  function automatic logic [6:0] seg7(input logic [7:0] c);
    case (c)
      "0": return 7'b0111111;
      "1": return 7'b0000110;
      "2": return 7'b1011011;
      "3": return 7'b1001111;
      "4": return 7'b1100110;
      "5": return 7'b1101101;
      "6": return 7'b1111101;
      "7": return 7'b0000111;
      "8": return 7'b1111111;
      "9": return 7'b1101111;
      "-": return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [7:0] rand_char();
    int r;
    r = $urandom_range(0, 13);
    if (r < 10) return 8'h30 + 8'(r);
    if (r == 10) return 8'h2D;
    if (r == 11) return 8'h20;
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s at cycle %0d: got %h, expected %h", tag, e, obs, exp);
    end
  endtask

  task automatic drive();
    {upper10, upper01, lower1000, lower0100, lower0010, lower0001} = nxt.chr;
    point = nxt.pt;
    col   = nxt.col;
    {TIM, MAX, DAY, AVS} = nxt.ann;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".seg"}, seg, 8'h00);
    chk({tag, ".digit_en"}, {2'b0, digit_en}, 8'h00);
    chk({tag, ".colon"}, {7'b0, colon}, 8'h00);
    chk({tag, ".ann"}, {4'b0, ann}, 8'h00);
    chk({tag, ".load_ack"}, {7'b0, load_ack}, 8'h00);
    chk({tag, ".frame_start"}, {7'b0, frame_start}, 8'h00);
  endtask

  // One clock: outputs at edge e reflect the slot position e-1 and the active buffer before the edge.
  task automatic step(input bit ld);
    int s, pcv, idxv;
    logic [7:0] xs;
    logic [5:0] xe;
    bit fs;
    drive();
    load = ld;
    @(posedge clock);
    #1;
    e++;
    s    = e - 1;
    pcv  = s % SD;
    idxv = (s / SD) % 6;
    xs = 8'h00;
    xe = 6'b0;
    if (pcv >= BC) begin
      xe = 6'(1 << idxv);
      xs = {(idxv == 1) && m_act.pt, seg7(m_act.chr[idxv])};
`ifdef DISP_PWM_EN
      if (((pcv - BC) % 8) > m_br) xe = 6'b0;
`endif
    end
    fs = (e % FR == 0);
    if (fs) begin
      m_act = m_sh;
`ifdef DISP_PWM_EN
      m_br = int'(brightness);
`endif
    end
    if (ld) m_sh = nxt;
    chk("seg", seg, xs);
    chk("digit_en", {2'b0, digit_en}, {2'b0, xe});
    chk("colon", {7'b0, colon}, {7'b0, m_act.col});
    chk("ann", {4'b0, ann}, {4'b0, m_act.ann});
    chk("frame_start", {7'b0, frame_start}, {7'b0, fs});
    chk("load_ack", {7'b0, load_ack}, {7'b0, ld});
    load = 1'b0;
  endtask

  task automatic run_until(input int pos);
    step(1'b0);
    for (int i = 0; i < FR && (e % FR) != pos; i++) step(1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk_zero("rst_now");
    repeat (3) @(posedge clock);
    #1;
    chk_zero("rst_hold");
    @(negedge clock);
    reset = 1'b0;
    e = 0;
    m_sh = blank_buf;
    m_act = blank_buf;
    m_br = 7;
  endtask

  initial begin
    blank_buf = buf_t'({{6{8'h20}}, 6'b0});
    nxt = blank_buf;
    drive();
    #1;
    do_reset();

    // Two idle frames of blanks.
    repeat (2 * FR) step(1'b0);

    // "12.34"
    run_until(50);
    nxt.chr = {" ", "1", "2", "3", "4", " "};
    nxt.pt  = 1'b1;
    step(1'b1);
    run_until(42);
    chk("d1234.idx1", seg, 8'hE6);
    run_until(138);
    chk("d1234.idx4", seg, 8'h06);
    run_until(170);
    chk("d1234.idx5", seg, 8'h00);
    run_until(10);
    chk("d1234.idx0", seg, 8'h00);

    // Colon and TIM annunciator, never blanked.
    run_until(60);
    nxt.col = 1'b1;
    nxt.ann = 4'b1000;
    step(1'b1);
    chk("col.before", {7'b0, colon}, 8'h00);
    run_until(0);
    chk("col.fs", {7'b0, frame_start}, 8'h01);
    chk("col.colon", {7'b0, colon}, 8'h01);
    chk("col.ann", {4'b0, ann}, 8'h08);
    step(1'b0);
    chk("col.blankslot", {7'b0, colon}, 8'h01);

    // All '8' loaded on the refresh cycle itself.
    run_until(FR - 1);
    nxt.chr = {6{"8"}};
    nxt.pt  = 1'b0;
    nxt.col = 1'b0;
    nxt.ann = 4'b0;
    step(1'b1);
    run_until(106);
    chk("r8.old_idx3", seg, 8'h5B);
    run_until(10);
    chk("r8.new_idx0", seg, 8'h7F);
    run_until(42);
    chk("r8.new_idx1", seg, 8'h7F);
    run_until(170);
    chk("r8.new_idx5", seg, 8'h7F);

    // Random loads, including back-to-back ones.
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 250)) step(1'b0);
      for (int d = 0; d < 6; d++) nxt.chr[d] = rand_char();
      nxt.pt  = 1'($urandom_range(0, 1));
      nxt.col = 1'($urandom_range(0, 1));
      nxt.ann = 4'($urandom_range(0, 15));
`ifdef DISP_PWM_EN
      brightness = 3'($urandom_range(0, 7));
`endif
      step(1'b1);
    end
    repeat (2 * FR) step(1'b0);

    // Reset at idx 3, pc 10, then resume from idx 0 with blanks.
    run_until(3 * SD + 10);
    #2;
    do_reset();
    repeat (3) step(1'b0);
    chk("rst_resume.en", {2'b0, digit_en}, 8'h01);
    repeat (FR) step(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
